// File: rtl/hazard_pkg.sv
// Shared types, default latencies and helpers for the MIPS hazard unit.
// Imported by the hazard controller and its MUL/DIV busy tracker.
package hazard_pkg;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Individual stall causes, kept apart for readability
    typedef struct packed {
        logic lw;
        logic br;
        logic jr;
        logic md;
    } hz_cause_t;

    localparam int DEF_REG_AW  = 5;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 16;
    localparam int DEF_CNT_W   = 32;

    // ceil(log2(v)) but never below one bit
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_md_busy_tracker.sv
// Occupancy counter for the multi-cycle MUL/DIV unit.
// A start reloads the counter; busy includes the issue cycle itself.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mul_start_i,
    input  logic div_start_i,
    output logic md_busy_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = clog2_min1(MAX_LAT);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    logic [CW-1:0] md_cnt_d;
    logic [CW-1:0] md_cnt_q;

    // Next count: divide beats multiply, any start reloads, else drain
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (div_start_i) begin
            md_cnt_d = DIV_LOAD;
        end else if (mul_start_i) begin
            md_cnt_d = MUL_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    // Remaining-cycles register, cleared at once by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy_o = (md_cnt_q != '0) | mul_start_i | div_start_i;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
// Adds qualified jr stalls, MUL/DIV occupancy and saturating event counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic              JumpRegD,
    input  logic              PCSrcD,
    input  logic              MdUseD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteW,
    input  logic              MulStartE,
    input  logic              DivStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    fwd_sel_t   fwd_a_e;
    fwd_sel_t   fwd_b_e;
    hz_cause_t  hz;
    logic       stall;
    logic       flush_d;
    logic       md_busy;

    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;

    // Register-write hits from EX, loads in MEM, used by branch/jr checks
    logic rs_hit_e;
    logic rt_hit_e;
    logic rs_hit_mld;
    logic rt_hit_mld;

    assign rs_hit_e   = RegWriteE && (WriteRegE != '0)
                        && (WriteRegE == RsD);
    assign rt_hit_e   = RegWriteE && (WriteRegE != '0)
                        && (WriteRegE == RtD);
    assign rs_hit_mld = MemtoRegM && (WriteRegM != '0)
                        && (WriteRegM == RsD);
    assign rt_hit_mld = MemtoRegM && (WriteRegM != '0)
                        && (WriteRegM == RtD);

    // EX operand A source: MEM result beats WB result, $0 never forwards
    always_comb begin
        fwd_a_e = FWD_RF;
        if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM) begin
            fwd_a_e = FWD_MEM;
        end else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW) begin
            fwd_a_e = FWD_WB;
        end
    end

    // EX operand B source, same priority as operand A
    always_comb begin
        fwd_b_e = FWD_RF;
        if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM) begin
            fwd_b_e = FWD_MEM;
        end else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW) begin
            fwd_b_e = FWD_WB;
        end
    end

    assign ForwardAE = fwd_a_e;
    assign ForwardBE = fwd_b_e;

    assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    md_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md (
        .clk_i       (CLK),
        .rst_i       (reset),
        .mul_start_i (MulStartE),
        .div_start_i (DivStartE),
        .md_busy_o   (md_busy)
    );

    assign MdBusy = md_busy;

    // Collect the four stall causes; jr only cares about its Rs
    always_comb begin
        hz    = '0;
        hz.lw = MemtoRegE && (RtE != '0)
                && ((RsD == RtE) || (RtD == RtE));
        hz.br = BranchD
                && (rs_hit_e || rt_hit_e || rs_hit_mld || rt_hit_mld);
        hz.jr = JumpRegD && (rs_hit_e || rs_hit_mld);
        hz.md = MdUseD && md_busy;
    end

    assign stall   = |hz;
    assign flush_d = (PCSrcD | JumpRegD) & ~stall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = flush_d;

    // Saturating increments for both event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter state, cleared asynchronously
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Table-driven bench for hazard_unit_mc with a queue scoreboard.
// A second instance with 4-bit counters covers saturation.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic [4:0] rsd;
        logic [4:0] rtd;
        logic       br;
        logic       jr;
        logic       pcs;
        logic       mdu;
        logic [4:0] rse;
        logic [4:0] rte;
        logic [4:0] wre;
        logic       rwe;
        logic       m2re;
        logic [4:0] wrm;
        logic       rwm;
        logic       m2rm;
        logic [4:0] wrw;
        logic       rww;
        logic       mul;
        logic       div;
    } in_t;

    typedef struct packed {
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       stall;
        logic       flush;
        logic       busy;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic CLK = 1'b0;
    logic reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, JumpRegD, PCSrcD, MdUseD;
    logic RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic MulStartE, DivStartE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE, MdBusy;
    logic [31:0] StallCnt, FlushCnt;

    logic [1:0]  s_fae, s_fbe;
    logic        s_fad, s_fbd, s_sf, s_sd, s_fd, s_fe, s_busy;
    logic [3:0]  s_sc, s_fc;

    int nvec = 0;
    int nerr = 0;
    int unsigned exp_sc = 0, exp_fc = 0, exp_ssc = 0, exp_sfc = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    hazard_unit_mc #(
        .REG_AW(5), .MUL_LAT(4), .DIV_LAT(16), .CNT_W(32)
    ) dut (
        .CLK(CLK), .reset(reset),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpRegD(JumpRegD),
        .PCSrcD(PCSrcD), .MdUseD(MdUseD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .MulStartE(MulStartE), .DivStartE(DivStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MdBusy(MdBusy), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_unit_mc #(
        .REG_AW(5), .MUL_LAT(4), .DIV_LAT(16), .CNT_W(4)
    ) u_sat (
        .CLK(CLK), .reset(reset),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpRegD(JumpRegD),
        .PCSrcD(PCSrcD), .MdUseD(MdUseD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .MulStartE(MulStartE), .DivStartE(DivStartE),
        .ForwardAE(s_fae), .ForwardBE(s_fbe),
        .ForwardAD(s_fad), .ForwardBD(s_fbd),
        .StallF(s_sf), .StallD(s_sd), .FlushD(s_fd), .FlushE(s_fe),
        .MdBusy(s_busy), .StallCnt(s_sc), .FlushCnt(s_fc)
    );

    task automatic chk(input string nm, input int unsigned act,
                       input int unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk_cnt();
        chk("StallCnt", StallCnt, exp_sc);
        chk("FlushCnt", FlushCnt, exp_fc);
        chk("sat.StallCnt", 32'(s_sc), exp_ssc);
        chk("sat.FlushCnt", 32'(s_fc), exp_sfc);
    endtask

    task automatic set_in(input in_t v);
        RsD = v.rsd; RtD = v.rtd; BranchD = v.br; JumpRegD = v.jr;
        PCSrcD = v.pcs; MdUseD = v.mdu; RsE = v.rse; RtE = v.rte;
        WriteRegE = v.wre; RegWriteE = v.rwe; MemtoRegE = v.m2re;
        WriteRegM = v.wrm; RegWriteM = v.rwm; MemtoRegM = v.m2rm;
        WriteRegW = v.wrw; RegWriteW = v.rww;
        MulStartE = v.mul; DivStartE = v.div;
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fae));
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fbe));
        chk("ForwardAD", 32'(ForwardAD), 32'(e.fad));
        chk("ForwardBD", 32'(ForwardBD), 32'(e.fbd));
        chk("StallF", 32'(StallF), 32'(e.stall));
        chk("StallD", 32'(StallD), 32'(e.stall));
        chk("FlushE", 32'(FlushE), 32'(e.stall));
        chk("FlushD", 32'(FlushD), 32'(e.flush));
        chk("MdBusy", 32'(MdBusy), 32'(e.busy));
        chk("sat.outputs",
            32'({s_fae, s_fbe, s_fad, s_fbd, s_sf, s_sd, s_fd, s_fe, s_busy}),
            32'({e.fae, e.fbe, e.fad, e.fbd, e.stall, e.stall, e.flush,
                 e.stall, e.busy}));
        if (!reset) begin
            if (e.stall) begin
                exp_sc++;
                if (exp_ssc < 15) exp_ssc++;
            end
            if (e.flush) begin
                exp_fc++;
                if (exp_sfc < 15) exp_sfc++;
            end
        end
    endtask

    task automatic drive(input in_t v, input exp_t e);
        @(posedge CLK);
        #1;
        chk_cnt();
        set_in(v);
        sb.push_back(e);
        @(negedge CLK);
        check_out();
    endtask

    initial begin
        in_t  v;
        exp_t e;

        reset = 1'b1;
        set_in('0);
        #12;
        chk("reset.MdBusy", 32'(MdBusy), 0);
        chk_cnt();
        @(negedge CLK);
        reset = 1'b0;

        tbl.push_back('{i:'0, e:'0});
        tbl.push_back('{i:'{rse:5'd3, wrm:5'd3, rwm:1'b1, wrw:5'd3,
                           rww:1'b1, default:'0},
                        e:'{fae:2'b10, default:'0}});
        tbl.push_back('{i:'{rse:5'd3, wrm:5'd3, wrw:5'd3, rww:1'b1,
                           default:'0},
                        e:'{fae:2'b01, default:'0}});
        tbl.push_back('{i:'{wrm:5'd3, rwm:1'b1, wrw:5'd3, rww:1'b1,
                           default:'0},
                        e:'0});
        tbl.push_back('{i:'{rte:5'd7, wrw:5'd7, rww:1'b1, wrm:5'd6,
                           rwm:1'b1, default:'0},
                        e:'{fbe:2'b01, default:'0}});
        tbl.push_back('{i:'{rsd:5'd4, rtd:5'd4, wrm:5'd4, rwm:1'b1,
                           default:'0},
                        e:'{fad:1'b1, fbd:1'b1, default:'0}});
        tbl.push_back('{i:'{rwm:1'b1, default:'0}, e:'0});
        tbl.push_back('{i:'{m2re:1'b1, rte:5'd5, rsd:5'd5, default:'0},
                        e:'{stall:1'b1, default:'0}});
        tbl.push_back('{i:'{m2re:1'b1, default:'0}, e:'0});
        tbl.push_back('{i:'{br:1'b1, pcs:1'b1, rsd:5'd2, rtd:5'd8,
                           rwe:1'b1, wre:5'd8, default:'0},
                        e:'{stall:1'b1, default:'0}});
        tbl.push_back('{i:'{br:1'b1, rsd:5'd2, m2rm:1'b1, wrm:5'd2,
                           rwm:1'b1, default:'0},
                        e:'{stall:1'b1, fad:1'b1, default:'0}});
        tbl.push_back('{i:'{br:1'b1, pcs:1'b1, rsd:5'd2, rtd:5'd3,
                           default:'0},
                        e:'{flush:1'b1, default:'0}});
        tbl.push_back('{i:'{jr:1'b1, rsd:5'd9, rtd:5'd10, rwe:1'b1,
                           wre:5'd10, default:'0},
                        e:'{flush:1'b1, default:'0}});
        tbl.push_back('{i:'{jr:1'b1, rwe:1'b1, default:'0},
                        e:'{flush:1'b1, default:'0}});
        tbl.push_back('{i:'{jr:1'b1, rsd:5'd31, rwe:1'b1, wre:5'd31,
                           default:'0},
                        e:'{stall:1'b1, default:'0}});
        tbl.push_back('{i:'{jr:1'b1, rsd:5'd12, m2rm:1'b1, wrm:5'd12,
                           rwm:1'b1, default:'0},
                        e:'{stall:1'b1, fad:1'b1, default:'0}});
        tbl.push_back('{i:'{mdu:1'b1, default:'0}, e:'0});
        tbl.push_back('{i:'{br:1'b1, rwe:1'b1, default:'0}, e:'0});

        foreach (tbl[k]) drive(tbl[k].i, tbl[k].e);

        // jr stalled, then resolved, then idle
        drive('{jr:1'b1, rsd:5'd31, wre:5'd31, rwe:1'b1, default:'0},
              '{stall:1'b1, default:'0});
        drive('{jr:1'b1, rsd:5'd31, wre:5'd31, default:'0},
              '{flush:1'b1, default:'0});
        drive('0, '0);

        // MUL, DIV, and both-start occupancy with a held consumer
        for (int c = 0; c < 6; c++) begin
            v = '{mdu:1'b1, default:'0};
            v.mul = (c == 0);
            e = '0;
            e.busy = (c <= 3);
            e.stall = (c <= 3);
            drive(v, e);
        end
        for (int c = 0; c < 18; c++) begin
            v = '{mdu:1'b1, default:'0};
            v.div = (c == 0);
            e = '0;
            e.busy = (c <= 15);
            e.stall = (c <= 15);
            drive(v, e);
        end
        for (int c = 0; c < 18; c++) begin
            v = '{mdu:1'b1, default:'0};
            v.div = (c == 0);
            v.mul = (c == 0);
            e = '0;
            e.busy = (c <= 15);
            e.stall = (c <= 15);
            drive(v, e);
        end

        // Reset in the middle of a divide
        for (int c = 0; c < 6; c++) begin
            v = '0;
            v.div = (c == 0);
            e = '{busy:1'b1, default:'0};
            drive(v, e);
        end
        #1;
        reset = 1'b1;
        #1;
        exp_sc = 0; exp_fc = 0; exp_ssc = 0; exp_sfc = 0;
        chk("rst.MdBusy", 32'(MdBusy), 0);
        chk_cnt();
        #1;
        reset = 1'b0;
        drive('{mdu:1'b1, default:'0}, '0);

        // Long load-use stall saturates the narrow counter
        for (int c = 0; c < 20; c++) begin
            drive('{m2re:1'b1, rte:5'd5, rsd:5'd5, default:'0},
                  '{stall:1'b1, default:'0});
        end
        drive('0, '0);
        chk("sat.StallCnt.final", 32'(s_sc), 15);
        chk("sb.empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
